// File: rtl/dmem_pkg.sv
// Shared funct3 encodings and byte-lane helpers for the byte-enabled data memory.
// Helpers work on a 64-bit view; 32-bit builds truncate the results.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 4'd1;
            F3_H, F3_HU: return 4'd2;
            F3_W, F3_WU: return 4'd4;
            default:     return 4'd8;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] funct3, input logic store, input logic wide);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_D:             return wide;
            F3_BU, F3_HU:     return !store;
            F3_WU:            return wide && !store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] funct3, input logic [2:0] offset);
        logic [15:0] base;
        base = (16'd1 << size_bytes(funct3)) - 16'd1;
        return base[7:0] << offset;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] funct3,
                                                input logic [2:0] offset);
        logic [63:0] s;
        s = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    return {{56{s[7]}}, s[7:0]};
            F3_H:    return {{48{s[15]}}, s[15:0]};
            F3_W:    return {{32{s[31]}}, s[31:0]};
            F3_BU:   return {56'd0, s[7:0]};
            F3_HU:   return {48'd0, s[15:0]};
            F3_WU:   return {32'd0, s[31:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module dmem_ram #(
    parameter int WORD_AW  = 11,
    parameter int NB_LANES = 4
) (
    input  logic                    clk,
    input  logic                    re,
    input  logic [NB_LANES-1:0]     be,
    input  logic [WORD_AW-1:0]      waddr,
    input  logic [NB_LANES*8-1:0]   wdata,
    output logic [NB_LANES*8-1:0]   rdata
);

    logic [NB_LANES*8-1:0] mem [2**WORD_AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_LANES; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[waddr];
    end

endmodule

// File: rtl/mem_data_be.sv
// Byte-addressed RV data memory with LB..SD formatting and a 1-cycle load result.
// Optional DMEM_ERR_EN: fault on misaligned/illegal accesses instead of force-aligning.
module mem_data_be
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    output logic                  ready,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rvalid,
    output logic                  err
);

    localparam int         NB_LANES = DATA_WIDTH / 8;
    localparam int         OFF_W    = $clog2(NB_LANES);
    localparam int         WORD_AW  = ADDR_WIDTH - OFF_W;
    localparam logic       WIDE     = (DATA_WIDTH == 64);
    localparam logic [2:0] FULL_F3  = WIDE ? F3_D : F3_W;

    // Handshake: a request is taken at any rising edge with req && ready; ready is simply
    // !rst, so there is no backpressure. A load answers with a one-cycle rvalid next cycle.
    logic                  accept;
    logic                  legal;
    logic                  misaligned;
    logic                  fault;
    logic [2:0]            eff_f3;
    logic [2:0]            off_raw;
    logic [2:0]            eff_off;
    logic [2:0]            align_mask;
    logic [3:0]            size;
    logic [NB_LANES-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] load_value;

    logic                  ld_pend;
    logic                  ld_fault;
    logic [2:0]            ld_f3;
    logic [2:0]            ld_off;
    logic [DATA_WIDTH-1:0] dout_q;

    always_comb begin
        accept     = req && !rst;
        off_raw    = 3'(addr[OFF_W-1:0]);
        legal      = f3_legal(funct3, we, WIDE);
        eff_f3     = legal ? funct3 : FULL_F3;
        size       = size_bytes(eff_f3);
        align_mask = 3'(size - 4'd1);
        misaligned = (off_raw & align_mask) != 3'd0;
`ifdef DMEM_ERR_EN
        fault      = !legal || misaligned;
        eff_off    = off_raw;
`else
        fault      = 1'b0;
        eff_off    = off_raw & ~align_mask;
`endif
        be         = (accept && we && !fault) ? NB_LANES'(lane_mask(eff_f3, eff_off)) : '0;
        wdata      = DATA_WIDTH'(64'(dataIn) << {eff_off, 3'b000});
    end

    dmem_ram #(
        .WORD_AW  (WORD_AW),
        .NB_LANES (NB_LANES)
    ) u_ram (
        .clk   (clk),
        .re    (accept && !we),
        .be    (be),
        .waddr (addr[ADDR_WIDTH-1:OFF_W]),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign load_value = ld_fault ? '0 : DATA_WIDTH'(load_extend(64'(rdata), ld_f3, ld_off));

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_pend  <= 1'b0;
            ld_fault <= 1'b0;
            ld_f3    <= 3'd0;
            ld_off   <= 3'd0;
            dout_q   <= '0;
        end else begin
            ld_pend  <= accept && !we;
            ld_fault <= accept && !we && fault;
            ld_f3    <= eff_f3;
            ld_off   <= eff_off;
            if (ld_pend) dout_q <= load_value;
        end
    end

`ifdef DMEM_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept && fault;
    end
    assign err = err_q && !rst;
`else
    assign err = 1'b0;
`endif

    // Outputs are gated by rst so a reset arriving mid-load suppresses the pending result.
    assign ready  = !rst;
    assign rvalid = ld_pend && !rst;
    assign dout   = rst ? '0 : (ld_pend ? load_value : dout_q);

endmodule

// File: doc/mem_data_be.md
Name: mem_data_be

Overview:
- Parametrised successor to the word-only data memory.
- Byte-addressed, byte-lane-enabled RV32I data RAM implementing LB/LH/LW/LBU/LHU and SB/SH/SW, selected by the instruction's funct3.
- Generalised to 32- or 64-bit words (64 adds LD/LWU/SD).
- Sits behind the core's MEM stage with a req/ready/rvalid handshake and synchronous (BRAM-style) read.

Parameters:
- ADDR_WIDTH, 13: byte-address width; depth = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
- DATA_WIDTH, 32: word width, 32 or 64 only; NB_LANES = DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request.
- ready  out  1  request accepted at the edge where req && ready.
- we  in  1  1 = store, 0 = load.
- addr  in  ADDR_WIDTH  byte address.
- funct3  in  3  RV access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- dataIn  in  DATA_WIDTH  store data, LSB-aligned.
- dout  out  DATA_WIDTH  formatted, extended load data.
- rvalid  out  1  one-cycle pulse: load result (or error) on dout.
- err  out  1  one-cycle pulse: access fault.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: rvalid=0, err=0, dout=0, ready=0 during any cycle with rst=1. RAM contents are NOT cleared.
- ready=1 whenever rst=0; the block is never busy, giving one access per cycle.
- Store accepted at edge N: the lanes selected by size and addr low bits are written at edge N. dataIn bits [8k-1:0] are shifted to the lane offset. Unselected lanes are unchanged. No rvalid.
- Load accepted at edge N: the RAM word is read at edge N; funct3 and lane offset are registered.
  - During cycle N+1, rvalid=1 and dout = selected bytes, sign-extended (B/H/W) or zero-extended (BU/HU/WU).
  - Load-to-use latency is 1 cycle.
- dout holds the last load result while rvalid=0. Stores never change dout.
- Back-to-back store then load to the same address: the load at edge N+1 returns the stored data.
- Legal funct3:
  - DATA_WIDTH=32 loads: 000, 001, 010, 100, 101.
  - DATA_WIDTH=32 stores: 000, 001, 010.
  - DATA_WIDTH=64 adds 011 (load/store) and 110 (load).
- Reset mid-operation: a load accepted at edge N with rst=1 at edge N+1 produces no rvalid, and dout clears to 0. A request presented while rst=1 is ignored, including a store, which does not write.

Optional Feature:
- DMEM_ERR_EN defined:
  - A misaligned access raises err. Misaligned means H with addr[0]!=0, W/WU with addr[1:0]!=0, or D with addr[2:0]!=0.
  - An illegal funct3 for the direction/width also raises err.
  - A faulting store writes nothing; err pulses at N+1.
  - A faulting load pulses err and rvalid together at N+1 with dout=0.
- DMEM_ERR_EN undefined:
  - err is tied 0.
  - Misaligned addresses are force-aligned by clearing the low offset bits for the access size.
  - An illegal funct3 is treated as a full-word access, sign-extended for loads.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - Function lane_mask(funct3, offset) returning the NB_LANES byte enable.
  - Function load_extend(word, funct3, offset).
- One sub-module, dmem_ram: a plain BRAM-inferable array with per-byte write enable and synchronous read.

Test Plan:
- SW 0x12345678 @0x0, then LW @0x0 → next cycle rvalid=1, dout=0x12345678.
- SB 0xAB @0x5 onto word 0x87654321 @0x4, then LW @0x4 → 0x8765AB21. LB @0x5 → 0xFFFFFFAB. LBU @0x5 → 0x000000AB.
- SH 0x8001 @0x2, then LH @0x2 → 0xFFFF8001. LHU @0x2 → 0x00008001. Bytes 0-1 unchanged.
- Back-to-back SW 0xDDDDDDDD @0x8 at edge N, LW @0x8 at edge N+1 → dout=0xDDDDDDDD at N+2. rvalid is high exactly one cycle.
- DMEM_ERR_EN: LW @0x2 → err=1, rvalid=1, dout=0. SH @0x1 → err=1, and memory is unchanged on re-read.
- LW accepted, rst=1 on next edge → rvalid stays 0, dout=0, ready=0. After rst drops, prior RAM contents still read back correctly.
